// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 icode constants and length helpers shared by fetch and loader
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    return (icode inside {I_HALT, I_NOP, I_RET}) ? 4'd1 :
           (icode inside {I_JXX, I_CALL}) ? 4'd9 :
           (icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ}) ? 4'd10 : 4'd2;
  endfunction

  function automatic logic has_reg(input logic [3:0] icode);
    return !(icode inside {I_HALT, I_NOP, I_RET, I_JXX, I_CALL});
  endfunction
endpackage

// File: rtl/y86_imem_loader_if.sv
// y86_imem_loader_if: instruction-field handshake plus imem byte write port
interface y86_imem_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_icode;
  logic [3:0]        in_ifun;
  logic [3:0]        in_ra;
  logic [3:0]        in_rb;
  logic [63:0]       in_valc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid, in_icode, in_ifun, in_ra, in_rb, in_valc,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_icode, in_ifun, in_ra, in_rb, in_valc,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/y86_encoder.sv
// y86_encoder: canonical Y86-64 byte image (byte0 in bits [7:0]) and length
module y86_encoder
  import y86_pkg::*;
(
  input  logic [3:0]       icode_i,
  input  logic [3:0]       ifun_i,
  input  logic [3:0]       ra_i,
  input  logic [3:0]       rb_i,
  input  logic [63:0]      valc_i,
  output logic [9:0][7:0]  bytes_o,
  output logic [3:0]       len_o
);
  logic [3:0] ifun, ra, rb;

  always_comb begin
    ifun    = (icode_i inside {I_HALT, I_NOP, I_RET}) ? 4'h0 : ifun_i;
    ra      = (icode_i == I_IRMOVQ) ? R_NONE : ra_i;
    rb      = (icode_i inside {I_PUSHQ, I_POPQ}) ? R_NONE : rb_i;
    bytes_o = has_reg(icode_i) ? {valc_i, ra, rb, icode_i, ifun} : {8'h00, valc_i, icode_i, ifun};
    len_o   = instr_len(icode_i);
  end
endmodule

// File: rtl/y86_imem_loader.sv
// y86_imem_loader: encodes accepted instructions and writes them byte-serially into imem
module y86_imem_loader
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  y86_imem_loader_if.slave  bus,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic              busy_o,
  output logic [15:0]       instr_count_o,
  output logic              err_icode_o,
  output logic              err_full_o
);
  // one extra pointer bit lets the pointer sit at MEM_DEPTH without wrapping
  localparam int PW = ADDR_W + 1;
  localparam int CW = ADDR_W + 4;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, ptr_nxt;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       icode_q, ifun_q, ra_q, rb_q, len;
  logic [63:0]      valc_q;
  logic [9:0][7:0]  bytes;
  logic [15:0]      cnt_q, cnt_d;
  logic             erri_q, erri_d, errf_q, errf_d;
  logic             busy, last, acc, bad, full, start;
  logic [CW-1:0]    need;

  y86_encoder u_enc (
    .icode_i (icode_q),
    .ifun_i  (ifun_q),
    .ra_i    (ra_q),
    .rb_i    (rb_q),
    .valc_i  (valc_q),
    .bytes_o (bytes),
    .len_o   (len)
  );

  always_comb begin
    busy         = state_q == EMIT;
    last         = busy && idx_q == len - 4'd1;
    bus.in_ready = !clr_i && (!busy || last);
    acc          = bus.in_valid && bus.in_ready;
    ptr_nxt      = busy ? ptr_q + PW'(1) : ptr_q;
    need         = CW'(ptr_nxt) + CW'(instr_len(bus.in_icode));
    bad          = bus.in_icode > I_POPQ;
    full         = need > CW'(MEM_DEPTH);
    start        = acc && !bad && !full;
    state_d      = clr_i ? IDLE : (start || (busy && !last)) ? EMIT : IDLE;
    idx_d        = start ? 4'd0 : busy ? idx_q + 4'd1 : idx_q;
    ptr_d        = clr_i ? PW'(BASE_ADDR) : ptr_nxt;
    cnt_d        = clr_i ? 16'd0 : (last && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    erri_d       = !clr_i && (erri_q || (acc && bad));
    errf_d       = !clr_i && (errf_q || (acc && !bad && full));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PW'(BASE_ADDR);
      idx_q   <= '0;
      cnt_q   <= '0;
      erri_q  <= 1'b0;
      errf_q  <= 1'b0;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      valc_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      erri_q  <= erri_d;
      errf_q  <= errf_d;
      if (start) begin
        icode_q <= bus.in_icode;
        ifun_q  <= bus.in_ifun;
        ra_q    <= bus.in_ra;
        rb_q    <= bus.in_rb;
        valc_q  <= bus.in_valc;
      end
    end
  end

  assign bus.mem_we    = busy;
  assign bus.mem_addr  = busy ? ptr_q[ADDR_W-1:0] : '0;
  assign bus.mem_wdata = busy ? bytes[idx_q] : 8'h00;
  assign wr_ptr_o      = ptr_q[ADDR_W-1:0];
  assign busy_o        = busy;
  assign instr_count_o = cnt_q;
  assign err_icode_o   = erri_q;
  assign err_full_o    = errf_q;
endmodule

// File: tb/tb_y86_imem_loader.sv
// tb_y86_imem_loader: directed checks of encoding, handshake, fit, icode errors and clr
module tb_y86_imem_loader;
  import y86_pkg::*;
  localparam int AW = 10;

  logic          clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [AW-1:0] wr_ptr;
  logic          busy, err_icode, err_full;
  logic [15:0]   cnt;
  int            tests = 0, fails = 0, cyc = 0;
  int            la[$], ld[$], lc[$];

  y86_imem_loader_if #(.ADDR_W(AW)) bus ();

  y86_imem_loader #(.ADDR_W(AW), .MEM_DEPTH(16), .BASE_ADDR(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (clr),
    .bus           (bus),
    .wr_ptr_o      (wr_ptr),
    .busy_o        (busy),
    .instr_count_o (cnt),
    .err_icode_o   (err_icode),
    .err_full_o    (err_full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rst_n && bus.mem_we) begin
      la.push_back(int'(bus.mem_addr));
      ld.push_back(int'(bus.mem_wdata));
      lc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_icode = ic;
    bus.in_ifun  = fn;
    bus.in_ra    = ra;
    bus.in_rb    = rb;
    bus.in_valc  = vc;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_wait", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    la.delete();
    ld.delete();
    lc.delete();
  endtask

  task automatic chk_log(input string tag, input int li, input int a0,
                         input logic [79:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      if (li + i < la.size()) begin
        chk({tag, "_addr"}, 64'(la[li+i]), 64'(a0 + i));
        chk({tag, "_byte"}, 64'(ld[li+i]), 64'(exp[i*8 +: 8]));
      end else begin
        chk({tag, "_count"}, 64'(la.size()), 64'(li + i + 1));
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_icode = '0;
    bus.in_ifun  = '0;
    bus.in_ra    = '0;
    bus.in_rb    = '0;
    bus.in_valc  = '0;
    #2;
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_we",    64'(bus.mem_we), 64'd0);
    chk("rst_addr",  64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_ptr",   64'(wr_ptr), 64'd0);
    chk("rst_cnt",   64'(cnt), 64'd0);
    chk("rst_erri",  64'(err_icode), 64'd0);
    chk("rst_errf",  64'(err_full), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(I_IRMOVQ, 4'h0, 4'h5, 4'h3, 64'h0102030405060708);
    drop();
    repeat (12) @(negedge clk);
    #1;
    chk("irmovq_n", 64'(la.size()), 64'd10);
    chk_log("irmovq", 0, 0, {64'h0102030405060708, 8'hF3, 8'h30}, 10);
    chk("irmovq_ptr", 64'(wr_ptr), 64'd10);
    chk("irmovq_cnt", 64'(cnt), 64'd1);

    do_clr();
    #1;
    chk("clr_ptr", 64'(wr_ptr), 64'd0);
    chk("clr_cnt", 64'(cnt), 64'd0);
    send(I_NOP, 4'h5, 4'h0, 4'h0, 64'd0);
    send(I_OPQ, 4'h0, 4'h2, 4'h3, 64'd0);
    send(I_RET, 4'h0, 4'h0, 4'h0, 64'd0);
    drop();
    repeat (5) @(negedge clk);
    #1;
    chk("b2b_n", 64'(la.size()), 64'd4);
    chk_log("b2b", 0, 0, 80'h90236010, 4);
    if (lc.size() == 4) chk("b2b_span", 64'(lc[3] - lc[0]), 64'd3);
    chk("b2b_ptr", 64'(wr_ptr), 64'd4);
    chk("b2b_cnt", 64'(cnt), 64'd3);

    do_clr();
    send(I_CALL, 4'h0, 4'h0, 4'h0, 64'h40);
    send(I_PUSHQ, 4'h0, 4'h4, 4'h0, 64'd0);
    drop();
    repeat (4) @(negedge clk);
    #1;
    chk("callpush_n", 64'(la.size()), 64'd11);
    chk_log("call", 0, 0, {8'h00, 64'h40, 8'h80}, 9);
    chk_log("push", 9, 9, 80'h4FA0, 2);
    chk("callpush_ptr", 64'(wr_ptr), 64'd11);

    do_clr();
    send(I_RMMOVQ, 4'h0, 4'h1, 4'h2, 64'd0);
    send(I_JXX, 4'h1, 4'h0, 4'h0, 64'h100);
    drop();
    repeat (3) @(negedge clk);
    #1;
    chk("fill_n", 64'(la.size()), 64'd10);
    chk("fill_errf", 64'(err_full), 64'd1);
    chk("fill_ptr", 64'(wr_ptr), 64'd10);
    chk("fill_cnt", 64'(cnt), 64'd1);
    send(I_RRMOVQ, 4'h0, 4'h1, 4'h2, 64'd0);
    send(I_RRMOVQ, 4'h0, 4'h1, 4'h2, 64'd0);
    send(I_RRMOVQ, 4'h0, 4'h1, 4'h2, 64'd0);
    send(I_NOP, 4'h0, 4'h0, 4'h0, 64'd0);
    drop();
    repeat (4) @(negedge clk);
    #1;
    chk("exact_n", 64'(la.size()), 64'd16);
    chk_log("exact", 10, 10, 80'h122012201220, 6);
    chk("exact_ptr", 64'(wr_ptr), 64'd16);
    chk("exact_cnt", 64'(cnt), 64'd4);

    do_clr();
    #1;
    chk("clr_errf", 64'(err_full), 64'd0);
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'd7);
    drop();
    repeat (3) @(negedge clk);
    #1;
    chk("badic_n", 64'(la.size()), 64'd0);
    chk("badic_err", 64'(err_icode), 64'd1);
    chk("badic_ptr", 64'(wr_ptr), 64'd0);
    send(I_HALT, 4'h3, 4'h0, 4'h0, 64'd0);
    drop();
    repeat (3) @(negedge clk);
    #1;
    chk("halt_n", 64'(la.size()), 64'd1);
    chk_log("halt", 0, 0, 80'h00, 1);
    chk("halt_ptr", 64'(wr_ptr), 64'd1);
    chk("halt_cnt", 64'(cnt), 64'd1);

    do_clr();
    send(I_RMMOVQ, 4'h0, 4'h1, 4'h2, 64'h11);
    drop();
    repeat (2) @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("abort_ready_clr", 64'(bus.in_ready), 64'd0);
    chk("abort_we4", 64'(bus.mem_we), 64'd1);
    chk("abort_addr4", 64'(bus.mem_addr), 64'd3);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("abort_we", 64'(bus.mem_we), 64'd0);
    chk("abort_n", 64'(la.size()), 64'd4);
    chk("abort_ptr", 64'(wr_ptr), 64'd0);
    chk("abort_cnt", 64'(cnt), 64'd0);
    chk("abort_erri", 64'(err_icode), 64'd0);
    chk("abort_errf", 64'(err_full), 64'd0);
    chk("abort_ready", 64'(bus.in_ready), 64'd1);

    send(I_IRMOVQ, 4'h0, 4'h0, 4'h1, 64'd5);
    drop();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_we", 64'(bus.mem_we), 64'd0);
    chk("arst_ptr", 64'(wr_ptr), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/y86_imem_loader.md
Name: y86_imem_loader

Overview:
- Writer side of the Y86-64 instruction memory. The fetch stage reads and decodes byte streams from that memory; this block performs the inverse.
- Accepts decoded instruction fields (icode, ifun, rA, rB, valC) over a valid/ready handshake.
- Encodes each instruction into its canonical variable-length Y86-64 byte sequence and writes it one byte per cycle into the instruction memory write port at a sequential program pointer.
- Used by testbenches and the boot path to load programs before the SEQ core runs.

Parameters:
- ADDR_W, 10, instruction memory byte-address width.
- MEM_DEPTH, 1024, number of writable bytes; legal addresses are BASE_ADDR..MEM_DEPTH-1.
- BASE_ADDR, 0, pointer value after reset and after clr.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous restart: pointer to BASE_ADDR, errors and count cleared.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  loader can accept an instruction this cycle.
- in_icode  in  4  instruction code.
- in_ifun  in  4  function code.
- in_rA  in  4  register A.
- in_rB  in  4  register B.
- in_valC  in  64  immediate, displacement or destination.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte address being written.
- mem_wdata  out  8  byte being written.
- wr_ptr  out  ADDR_W  next free byte address (the PC of the next loaded instruction).
- busy  out  1  emitting bytes.
- instr_count  out  16  instructions written completely; saturates at 16'hFFFF.
- err_icode  out  1  sticky: an icode greater than 4'hB was received.
- err_full  out  1  sticky: an instruction did not fit in memory.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE, wr_ptr = BASE_ADDR.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - busy = 0, in_ready = 1, instr_count = 0, both error flags = 0.
- Length by icode:
  - 1 byte: 0 (halt), 1 (nop), 9 (ret).
  - 2 bytes: 2 (cmovxx), 6 (OPq), A (pushq), B (popq).
  - 9 bytes: 7 (jxx), 8 (call).
  - 10 bytes: 3 (irmovq), 4 (rmmovq), 5 (mrmovq).
- Byte layout:
  - byte0 = {icode, ifun}.
  - byte1 = {rA, rB} when the instruction has a register byte.
  - valC follows, little-endian (valC[7:0] first).
  - jxx and call have no register byte; valC starts at byte1.
- Field forcing:
  - irmovq: rA forced to 4'hF.
  - pushq and popq: rB forced to 4'hF.
  - halt, nop, ret: ifun forced to 0.
- Handshake:
  - Transfer occurs when in_valid and in_ready are both high; fields are latched on that edge.
  - in_ready is high in IDLE, and during the final byte of EMIT, so instructions can load back-to-back with no bubble.
  - in_ready is low whenever clr is high.
- State machine IDLE / EMIT:
  - On accept of a valid, fitting instruction: go to EMIT and load a byte index of 0.
  - Each EMIT cycle: mem_we = 1, mem_addr = wr_ptr, mem_wdata = byte[index]; wr_ptr and index increment.
  - After the last byte: instr_count increments. The next state is EMIT if a new instruction was accepted on that cycle, otherwise IDLE.
  - The first byte is written on the cycle after accept; an instruction of L bytes occupies L cycles.
  - busy = (state == EMIT).
- Fit check at accept:
  - If wr_ptr + L > MEM_DEPTH: the instruction is consumed and dropped, err_full is set, and no byte is written. There are no partial writes.
  - Compute the check in ADDR_W+4 bits.
- Invalid icode:
  - icode greater than 4'hB: consumed and dropped, err_icode set, no write, pointer unchanged.
- clr:
  - Has priority over everything.
  - Next cycle: state IDLE, mem_we = 0, wr_ptr = BASE_ADDR, count and errors cleared.
  - An instruction in progress is aborted; bytes already written stay in memory.
  - clr asserted during an accept cycle: the instruction is dropped.
- Pointer at exact fit: wr_ptr may reach MEM_DEPTH. From then on, every instruction sets err_full. wr_ptr never wraps.
- rst_n asserted mid-EMIT: immediate return to reset values.

Decomposition:
- Shared package y86_pkg:
  - icode constants I_HALT through I_POPQ.
  - register constant R_NONE = 4'hF.
  - instruction-length function (by icode).
  - has-register-byte function (by icode).
  - The same package is used by the fetch stage, so encode and decode lengths agree by construction.
- One natural combinational sub-module, y86_encoder: latched fields in, a 10-byte packed vector and length out. The loader holds the FSM, pointer and handshake.

Test Plan:
- Reset, then irmovq with rB=3 and valC=64'h0102030405060708 -> mem writes at addresses 0..9 of bytes 30, F3, 08, 07, 06, 05, 04, 03, 02, 01; wr_ptr = 10; instr_count = 1.
- Back-to-back nop, OPq (ifun=0, rA=2, rB=3), ret with in_valid held high -> bytes 10, 60, 23, 90 on four consecutive cycles with no bubble; wr_ptr = 4.
- call with valC = 64'h40 -> 9 bytes: 80, 40, then seven 00 bytes; pushq with rA=4 and rB=0 -> bytes A0, 4F (rB forced to F).
- Fill: MEM_DEPTH = 16, load a 10-byte and then a 9-byte instruction -> second instruction dropped, err_full = 1, no write at address 10 or above, wr_ptr = 10.
- icode = 4'hC -> no mem_we, err_icode = 1, wr_ptr unchanged; a following valid halt writes 00 normally.
- clr on the 4th byte of rmmovq -> mem_we low on the next cycle; wr_ptr = 0, count = 0, errors = 0, in_ready = 1.
